// File: rtl/fir_pkg.sv
// Shared types and helpers for the serial-MAC FIR filter.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // c[0] sits in the LSBs; the default response is symmetric.
  localparam logic [95:0] COEF_INIT_DEFAULT = {16'd0, 16'd1, 16'd7, 16'd7, 16'd1, 16'd0};

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < value) r = r + 1;
    return r;
  endfunction

  // Clamp a sign-extended value into the signed range of dw bits.
  function automatic logic signed [63:0] sat(input logic signed [63:0] value, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/fir_serial_mac_if.sv
// Sample-in / result-out valid-ready streams of the FIR filter.
interface fir_serial_mac_if #(
  parameter int DW = 16
) ();
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;

  modport slave  (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data);
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data);
endinterface

// File: rtl/fir_coef_bank.sv
// Writable coefficient register file; rejects writes when not allowed or out of range.
module fir_coef_bank import fir_pkg::*; #(
  parameter int                     N_TAPS    = 6,
  parameter int                     CW        = 16,
  parameter int                     AW        = 3,
  parameter logic [N_TAPS*CW-1:0]   COEF_INIT = COEF_INIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic                 allow,
  input  logic [AW-1:0]        addr,
  input  logic signed [CW-1:0] wdata,
  input  logic [AW-1:0]        rd_addr,
  output logic signed [CW-1:0] rd_data,
  output logic                 err
);
  logic signed [CW-1:0] coef_r [N_TAPS];
  logic                 in_range_s;
  logic                 write_ok_s;

  assign in_range_s = (32'(addr) < N_TAPS);
  assign write_ok_s = we && allow && in_range_s;
  assign rd_data    = coef_r[rd_addr];

  // Coefficient storage plus the one-cycle reject pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_TAPS; k++) coef_r[k] <= COEF_INIT[k*CW +: CW];
      err <= 1'b0;
    end else begin
      err <= we && !write_ok_s;
      if (write_ok_s) coef_r[addr] <= wdata;
    end
  end
endmodule

// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR: one multiplier-accumulator walks all taps per accepted sample.
module fir_serial_mac import fir_pkg::*; #(
  parameter int                   N_TAPS    = 6,
  parameter int                   DW        = 16,
  parameter int                   CW        = 16,
  parameter int                   FRAC      = 0,
  parameter logic [N_TAPS*CW-1:0] COEF_INIT = COEF_INIT_DEFAULT,
  localparam int                  AW        = clog2(N_TAPS),
  localparam int                  ACC_W     = DW + CW + AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic signed [CW-1:0] coef_wdata,
  output logic                 coef_err,
  output logic                 busy,
  fir_serial_mac_if.slave      s
);
  state_t                  state_r, state_s;
  logic [AW-1:0]           tap_r;
  logic signed [DW-1:0]    x_r [N_TAPS];
  logic signed [ACC_W-1:0] acc_r;
  logic signed [CW-1:0]    coef_s;
  logic signed [DW+CW-1:0] prod_s;
  logic signed [ACC_W-1:0] shifted_s;
  logic signed [DW-1:0]    sat_s;
  logic                    out_valid_r;
  logic signed [DW-1:0]    out_data_r;
  logic                    idle_s, accept_s, last_tap_s, out_fire_s;

  assign idle_s     = (state_r == ST_IDLE);
  assign s.in_ready = idle_s && !clr;
  assign busy       = !idle_s;
  assign accept_s   = s.in_valid && s.in_ready;
  assign last_tap_s = (tap_r == AW'(N_TAPS - 1));
  assign out_fire_s = out_valid_r && s.out_ready;
  assign s.out_valid = out_valid_r;
  assign s.out_data  = out_data_r;

  fir_coef_bank #(.N_TAPS(N_TAPS), .CW(CW), .AW(AW), .COEF_INIT(COEF_INIT)) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (coef_we),
    .allow   (idle_s),
    .addr    (coef_addr),
    .wdata   (coef_wdata),
    .rd_addr (tap_r),
    .rd_data (coef_s),
    .err     (coef_err)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic; clr overrides everything.
  always_comb begin
    state_s = state_r;
    if (clr) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: if (accept_s)   state_s = ST_MAC; else state_s = ST_IDLE;
        ST_MAC:  if (last_tap_s) state_s = ST_OUT; else state_s = ST_MAC;
        ST_OUT:  if (out_fire_s) state_s = ST_IDLE; else state_s = ST_OUT;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Product, output scaling and saturation.
  always_comb begin
    prod_s    = x_r[tap_r] * coef_s;
    shifted_s = acc_r >>> FRAC;
    sat_s     = DW'(sat({{(64-ACC_W){shifted_s[ACC_W-1]}}, shifted_s}, DW));
  end

  // Delay line, tap counter and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_TAPS; k++) x_r[k] <= '0;
      acc_r <= '0;
      tap_r <= '0;
    end else if (clr) begin
      for (int k = 0; k < N_TAPS; k++) x_r[k] <= '0;
      acc_r <= '0;
      tap_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            for (int k = N_TAPS - 1; k > 0; k--) x_r[k] <= x_r[k-1];
            x_r[0] <= s.in_data;
            acc_r  <= '0;
            tap_r  <= '0;
          end
        end
        ST_MAC: begin
          acc_r <= acc_r + {{(ACC_W-DW-CW){prod_s[DW+CW-1]}}, prod_s};
          tap_r <= last_tap_s ? '0 : tap_r + AW'(1'b1);
        end
        default: ;
      endcase
    end
  end

  // Result register: loaded on the first OUT cycle, held until the sink takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
    end else if (clr) begin
      out_valid_r <= 1'b0;
    end else if (state_r == ST_OUT && !out_valid_r) begin
      out_valid_r <= 1'b1;
      out_data_r  <= sat_s;
    end else if (out_fire_s) begin
      out_valid_r <= 1'b0;
    end
  end
endmodule
